// File: rtl/spatial_acc_pkg.sv
// Shared definitions for the 4x4 spatial accumulator sequencer.
//   state_e      : controller states
//   NUM_LANES    : number of PE lanes (16)
//   ARR_DIM      : array row/column dimension (4)
//   lane_lsb()   : LSB position of a lane within a flattened bus
//   elem_idx()   : flattened lane index of weight element [row][col]
package spatial_acc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      CLEAR,
      STREAM,
      DRAIN,
      OUTPUT
   } state_e;

   localparam int unsigned NUM_LANES = 16;
   localparam int unsigned ARR_DIM   = 4;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

   function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
      return row * ARR_DIM + col;
   endfunction

endpackage

// File: rtl/spatial_acc_ctrl.sv
// Sequencer for the 4x4 spatial MAC array.
// Per job: latch a weight set, clear the array, stream cfg_len input
// vectors, wait out PE latency, then hand off the 16 accumulated results.
// Ports:
//   clk, rst (async active-low)
//   start/cfg_len/busy          : job request and status
//   w_valid/w_ready/w_data      : weight set handshake
//   in_valid/in_ready/in_data   : input vector handshake
//   arr_weight/arr_input/arr_en/arr_clr/arr_result : PE array interface
//   out_valid/out_ready/out_data/done : result handshake
module spatial_acc_ctrl
   import spatial_acc_pkg::*;
#(
   parameter int DW     = 16,
   parameter int AW     = 32,
   parameter int LEN_W  = 8,
   parameter int PE_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_W-1:0]        cfg_len,
   output logic                    busy,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [NUM_LANES*DW-1:0] w_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_LANES*DW-1:0] in_data,
   output logic [NUM_LANES*DW-1:0] arr_weight,
   output logic [NUM_LANES*DW-1:0] arr_input,
   output logic                    arr_en,
   output logic                    arr_clr,
   input  logic [NUM_LANES*AW-1:0] arr_result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_LANES*AW-1:0] out_data,
   output logic                    done
);

   // DRAIN lasts PE_LAT+1 cycles: the trailing arr_en plus the PE latency.
   localparam logic [2:0] DRAIN_LAST = 3'(PE_LAT);

   state_e                    state_q, state_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [LEN_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                drain_cnt_q, drain_cnt_d;
   logic [NUM_LANES*DW-1:0]   arr_weight_q, arr_weight_d;
   logic [NUM_LANES*DW-1:0]   arr_input_q, arr_input_d;
   logic                      arr_en_q, arr_en_d;
   logic [NUM_LANES*AW-1:0]   out_data_q, out_data_d;

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      drain_cnt_d  = drain_cnt_q;
      arr_weight_d = arr_weight_q;
      arr_input_d  = arr_input_q;
      arr_en_d     = 1'b0;
      out_data_d   = out_data_q;
      busy         = (state_q != IDLE);
      w_ready      = 1'b0;
      in_ready     = 1'b0;
      arr_clr      = 1'b0;
      out_valid    = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d       = cfg_len;
               cnt_d       = '0;
               drain_cnt_d = '0;
               state_d     = LOAD_W;
            end
         end
         LOAD_W: begin
            w_ready = 1'b1;
            if (w_valid) begin
               arr_weight_d = w_data;
               state_d      = CLEAR;
            end
         end
         CLEAR: begin
            arr_clr = 1'b1;
            state_d = (len_q == '0) ? DRAIN : STREAM;
         end
         STREAM: begin
            in_ready = (cnt_q < len_q);
            if (in_valid && in_ready) begin
               arr_input_d = in_data;
               arr_en_d    = 1'b1;
               // cnt_q < len_q here, so the increment cannot wrap.
               cnt_d       = cnt_q + 1'b1;
               if (cnt_d == len_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               out_data_d  = arr_result;
               drain_cnt_d = '0;
               state_d     = OUTPUT;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done    = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         drain_cnt_q  <= '0;
         arr_weight_q <= '0;
         arr_input_q  <= '0;
         arr_en_q     <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         arr_weight_q <= arr_weight_d;
         arr_input_q  <= arr_input_d;
         arr_en_q     <= arr_en_d;
         out_data_q   <= out_data_d;
      end
   end

   assign arr_weight = arr_weight_q;
   assign arr_input  = arr_input_q;
   assign arr_en     = arr_en_q;
   assign out_data   = out_data_q;

endmodule

// File: tb/tb_spatial_acc_ctrl.sv
// Self-checking bench for spatial_acc_ctrl with a behavioural PE array and
// an arithmetic reference of the expected per-lane sums.
module tb_spatial_acc_ctrl;
   import spatial_acc_pkg::*;

   localparam int DW     = 16;
   localparam int AW     = 32;
   localparam int LEN_W  = 8;
   localparam int PE_LAT = 1;
   localparam int NL     = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [LEN_W-1:0]    cfg_len = '0;
   logic                busy;
   logic                w_valid = 1'b0;
   logic                w_ready;
   logic [NL*DW-1:0]    w_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [NL*DW-1:0]    in_data = '0;
   logic [NL*DW-1:0]    arr_weight;
   logic [NL*DW-1:0]    arr_input;
   logic                arr_en;
   logic                arr_clr;
   logic [NL*AW-1:0]    arr_result;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [NL*AW-1:0]    out_data;
   logic                done;

   always #5 clk = ~clk;

   spatial_acc_ctrl #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .arr_weight(arr_weight), .arr_input(arr_input), .arr_en(arr_en),
      .arr_clr(arr_clr), .arr_result(arr_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .done(done)
   );

   // PE array: one-cycle MAC latency, not reset, cleared only by arr_clr.
   logic [AW-1:0] acc [NL] = '{default: '0};
   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (arr_clr)
            acc[i] <= '0;
         else if (arr_en)
            acc[i] <= acc[i] + AW'(arr_input[lane_lsb(i, DW) +: DW]) * AW'(arr_weight[lane_lsb(i, DW) +: DW]);
      end
   end
   always_comb begin
      arr_result = '0;
      for (int i = 0; i < NL; i++) arr_result[i*AW +: AW] = acc[i];
   end

   // Free-running event counters; tests use before/after snapshots.
   int unsigned en_cnt = 0, clr_cnt = 0, ir_cnt = 0, done_cnt = 0;
   always @(posedge clk) begin
      if (arr_en)   en_cnt   <= en_cnt + 1;
      if (arr_clr)  clr_cnt  <= clr_cnt + 1;
      if (in_ready) ir_cnt   <= ir_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   int checks = 0;
   int failures = 0;
   logic [NL*DW-1:0] last_w = '0;

   task automatic check(input string name, input logic [NL*AW-1:0] act, input logic [NL*AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // vmode: 0 = always valid, 1 = alternate 1/0, 2 = random
   task automatic run_job(input int len, input logic [NL*DW-1:0] w, input int vmode,
                          input logic [DW-1:0] ival, input bit irand, input int rdelay,
                          input bit spam, output logic [NL*AW-1:0] got);
      logic [AW-1:0]    sum [NL];
      logic [NL*AW-1:0] exp;
      logic [NL*AW-1:0] held;
      logic [NL*DW-1:0] v;
      int               sent;
      int               cyc;
      bit               tgl;
      int unsigned      e0, c0, i0, d0;
      e0 = en_cnt; c0 = clr_cnt; i0 = ir_cnt; d0 = done_cnt;
      for (int i = 0; i < NL; i++) sum[i] = '0;
      sent = 0; cyc = 0; tgl = 1'b1;

      start = 1'b1; cfg_len = LEN_W'(len);
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("w_ready_in_load", w_ready, 1);
      check("arr_weight_held", arr_weight, last_w);
      w_valid = 1'b1; w_data = w;
      tick();
      w_valid = 1'b0;
      check("w_ready_after_hs", w_ready, 0);
      check("arr_weight_loaded", arr_weight, w);
      check("arr_clr_in_clear", arr_clr, 1);
      last_w = w;

      while (!out_valid && cyc < 5000) begin
         if (spam) start = 1'($urandom_range(0, 1));
         case (vmode)
            0:       in_valid = (sent < len);
            1:       in_valid = (sent < len) && tgl;
            default: in_valid = (sent < len) && ($urandom_range(0, 1) == 1);
         endcase
         tgl = ~tgl;
         for (int i = 0; i < NL; i++) v[i*DW +: DW] = irand ? DW'($urandom) : ival;
         in_data = v;
         #1;
         if (in_valid && in_ready) begin
            sent++;
            for (int i = 0; i < NL; i++)
               sum[i] = sum[i] + AW'(v[i*DW +: DW]) * AW'(w[i*DW +: DW]);
         end
         tick();
         cyc++;
      end
      start = 1'b0; in_valid = 1'b0;
      check("out_valid_reached", out_valid, 1);
      check("vectors_accepted", sent, len);
      check("arr_en_count", en_cnt - e0, len);
      check("arr_clr_count", clr_cnt - c0, 1);
      if (len == 0) check("in_ready_len0", ir_cnt - i0, 0);

      for (int i = 0; i < NL; i++) exp[i*AW +: AW] = sum[i];
      check("out_data_model", out_data, exp);

      held = out_data;
      out_ready = 1'b0;
      for (int k = 0; k < rdelay; k++) begin
         tick();
         check("out_valid_hold", out_valid, 1);
         check("out_data_stable", out_data, held);
         check("no_early_done", done, 0);
      end
      out_ready = 1'b1;
      #1;
      check("done_with_ready", done, 1);
      tick();
      out_ready = 1'b0;
      #1;
      check("out_valid_dropped", out_valid, 0);
      check("busy_idle", busy, 0);
      check("done_single", done_cnt - d0, 1);
      got = held;
   endtask

   typedef struct {
      int            len;
      int            wmode;   // 0 = idx+1, 1 = all ones, 2 = random
      logic [DW-1:0] ival;
      bit            irand;
      int            vmode;
      int            rdelay;
      bit            spam;
      logic [AW-1:0] exp0;
      logic [AW-1:0] exp15;
   } vec_t;

   function automatic logic [NL*DW-1:0] make_w(input int mode);
      logic [NL*DW-1:0] w;
      for (int i = 0; i < NL; i++)
         w[i*DW +: DW] = (mode == 0) ? DW'(i + 1) : (mode == 1) ? DW'(1) : DW'($urandom);
      return w;
   endfunction

   initial begin
      vec_t             tbl [6];
      logic [NL*AW-1:0] got;
      logic [NL*DW-1:0] wv;

      tbl[0] = '{3,   0, 16'd2,    1'b0, 0, 0, 1'b0, 32'd6,        32'd96};
      tbl[1] = '{4,   0, 16'd2,    1'b0, 1, 5, 1'b0, 32'd8,        32'd128};
      tbl[2] = '{0,   2, 16'd0,    1'b1, 0, 2, 1'b0, 32'd0,        32'd0};
      tbl[3] = '{255, 1, 16'hFFFF, 1'b0, 0, 1, 1'b1, 32'd16711425, 32'd16711425};
      tbl[4] = '{2,   0, 16'd3,    1'b0, 0, 0, 1'b0, 32'd6,        32'd96};
      tbl[5] = '{2,   1, 16'd5,    1'b0, 2, 3, 1'b0, 32'd10,       32'd10};

      #2 rst = 1'b0;
      #10;
      check("rst_busy", busy, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_arr_en", arr_en, 0);
      check("rst_arr_clr", arr_clr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_arr_weight", arr_weight, 0);
      check("rst_arr_input", arr_input, 0);
      check("rst_out_data", out_data, 0);
      @(posedge clk); #1 rst = 1'b1;
      tick();

      // Reset in the middle of STREAM after two of four vectors.
      start = 1'b1; cfg_len = 8'd4;
      tick();
      start = 1'b0; w_valid = 1'b1; w_data = make_w(1);
      tick();
      w_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < NL; i++) in_data[i*DW +: DW] = 16'd9;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_arr_weight", arr_weight, 0);
      in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      last_w = '0;
      tick();
      run_job(1, make_w(1), 0, 16'd7, 1'b0, 0, 1'b0, got);
      check("after_rst_lane0", got[AW-1:0], 7);
      check("after_rst_lane15", got[NL*AW-1 -: AW], 7);

      for (int t = 0; t < 6; t++) begin
         run_job(tbl[t].len, make_w(tbl[t].wmode), tbl[t].vmode, tbl[t].ival,
                 tbl[t].irand, tbl[t].rdelay, tbl[t].spam, got);
         check($sformatf("tbl%0d_lane0", t), got[AW-1:0], tbl[t].exp0);
         check($sformatf("tbl%0d_lane15", t), got[NL*AW-1 -: AW], tbl[t].exp15);
      end

      for (int t = 0; t < 6; t++) begin
         wv = make_w(2);
         run_job(int'($urandom_range(1, 20)), wv, 2, 16'd0, 1'b1,
                 int'($urandom_range(0, 3)), 1'b1, got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
